alu_operand_stage: RTL and testbench
====================================

# alu_operand_stage

ID/EX pipeline stage that sits directly upstream of the ALU. It accepts decoded instructions from decode with a valid/ready handshake. It resolves operand A and operand B using immediate selection and EX/MEM and MEM/WB forwarding, detects load-use hazards, and registers `busA`, `busB` and `Ctrl` for the ALU. Held entries snoop writeback so that stalled operands never go stale.

## Interface
Parameters:
- `DW`, 32: datapath width; `busA`/`busB` width.
- `AW`, 5: register address width.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  decode presents an instruction.
- `in_ready`  out  1  stage accepts this cycle.
- `in_ctrl`  in  3  ALU op code (NOP..SLL, package encoding).
- `in_rs`, `in_rt`  in  AW  source register addresses.
- `in_rs_data`, `in_rt_data`  in  DW  register-file read data.
- `in_uses_rt`  in  1  rt is a true source (not imm-only).
- `in_use_imm`  in  1  busB takes the extended immediate.
- `in_sign_ext`  in  1  1 = sign-extend imm, 0 = zero-extend.
- `in_imm`  in  16  immediate.
- `in_rd`  in  AW  destination; `in_reg_write`  in  1.
- `exm_wr`, `exm_load`  in  1  EX/MEM writes a register / is a load.
- `exm_rd`  in  AW; `exm_data`  in  DW  EX/MEM result.
- `wb_wr`  in  1; `wb_rd`  in  AW; `wb_data`  in  DW  MEM/WB writeback.
- `flush`  in  1  kill held and incoming instruction.
- `out_valid`  out  1; `out_ready`  in  1  downstream handshake.
- `busA`, `busB`  out  DW  ALU operands.
- `Ctrl`  out  3  ALU op.
- `out_rd`  out  AW; `out_reg_write`  out  1.

## Operation
- Two states: EMPTY and FULL (`out_valid` = FULL).
- `in_ready` = (EMPTY or `out_ready`) and not `hazard` and not `flush`.
- `hazard` = `in_valid` and `exm_load` and `exm_wr` and `exm_rd` != 0 and (`exm_rd` == `in_rs`, or (`in_uses_rt` and not `in_use_imm` and `exm_rd` == `in_rt`)).
- Operand resolution at accept, per source:
  - Address 0 gives 0, with no forwarding.
  - Otherwise priority is EX/MEM (`exm_wr`, match, not load), then MEM/WB (`wb_wr`, match), then register file.
- `busB` = extended imm when `in_use_imm`.
- Ext rule: sign-extend copies `in_imm[15]` into bits DW-1:16.
- Transitions:
  - Accept moves to FULL, loading all outputs.
  - FULL with `out_ready` and no accept moves to EMPTY.
  - FULL with `out_ready` and accept stays FULL with the new entry (back-to-back).
  - FULL without `out_ready` holds.
- Hold snoop: while FULL and not `out_ready`, if `wb_wr` and `wb_rd` != 0 match the held rs (or rt, when rt is a source), replace `busA`/`busB` with `wb_data`. Immediate operands are never replaced.
- Bubble/EMPTY outputs: `Ctrl` = NOP, `busA` = `busB` = 0, `out_reg_write` = 0, `out_rd` = 0.
- `flush` has priority over everything: next state EMPTY, nothing accepted.

## Timing
- Reset (async, `rst_n` low): EMPTY, `out_valid` = 0, `Ctrl` = NOP, `busA` = `busB` = 0, `out_rd` = 0, `out_reg_write` = 0.
- Reset mid-hold discards the entry.
- Latency is 1 cycle: accepted at edge k, visible after edge k. Throughput is 1 per cycle.
- `in_ready` is combinational from `out_ready`, `flush` and forwarding inputs. There is no combinational path from `in_*` data to `busA`/`busB`/`Ctrl`.
- Load-use costs exactly one bubble. The next cycle the load sits in MEM/WB and forwards normally.
- Simultaneous EX/MEM and MEM/WB match to the same register: EX/MEM wins.
- Simultaneous `flush` and `out_ready`: the held entry counts as consumed, and the stage is EMPTY next cycle.

## Structure
- Shared package `alu_pkg`:
  - ALU ctrl constants NOP=000, ADD=001, SUB=010, AND=011, OR=100, XOR=101, SLT=110, SLL=111.
  - Forward-select enum {FWD_RF, FWD_EXM, FWD_WB, FWD_ZERO}.
- Sub-module `operand_forward`:
  - Instantiated twice, once per source.
  - Inputs: address, RF data, both forward buses.
  - Outputs: resolved value, select, hazard bit.
- The top holds the FSM, the registers and the snoop logic.

## Test plan
- Reset and idle: `rst_n` low mid-FULL → all outputs 0, `Ctrl` = 000, `out_valid` = 0 immediately. Idle cycles keep NOP.
- ADD r3 = r1 + r2 with RF r1 = 5, r2 = 7, no forwarding → after 1 cycle: `busA` = 5, `busB` = 7, `Ctrl` = 001, `out_rd` = 3. Back-to-back issue with `out_ready` = 1 keeps 1/cycle.
- Forwarding priority: `exm_rd` = `wb_rd` = 1, `exm_data` = 0xAA, `wb_data` = 0xBB, RF = 0x11 → `busA` = 0xAA. Source r0 with `exm_rd` = 0 → `busA` = 0.
- Immediate: `in_imm` = 0x8000, `in_sign_ext` = 1 → `busB` = 0xFFFF8000. With `in_sign_ext` = 0 → 0x00008000.
- Load-use: `exm_load` = 1, `exm_rd` = 4, decode reads r4 → `in_ready` = 0 for one cycle, one bubble (NOP). Next cycle `wb_data` = 0x1234 is captured into `busA`.
- Stall snoop and flush:
  - `out_ready` = 0 holding rs = 6 while `wb_rd` = 6, `wb_data` = 0x55 → `busA` becomes 0x55, and `Ctrl` is unchanged.
  - Then `flush` = 1 → `out_valid` = 0 next cycle, with no input accepted.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand stage: op codes, forwarding
// selects and the stage occupancy states.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_NOP = 3'b000,
    ALU_ADD = 3'b001,
    ALU_SUB = 3'b010,
    ALU_AND = 3'b011,
    ALU_OR  = 3'b100,
    ALU_XOR = 3'b101,
    ALU_SLT = 3'b110,
    ALU_SLL = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    FWD_RF,
    FWD_EXM,
    FWD_WB,
    FWD_ZERO
  } fwd_sel_t;

  typedef enum logic {
    ST_EMPTY,
    ST_FULL
  } stage_state_t;

  localparam int IMM_W = 16;

endpackage

// File: rtl/operand_forward.sv
// Resolves one source operand: register 0 reads as zero, otherwise the
// youngest producer wins (EX/MEM non-load, then MEM/WB, then the register
// file). A load still sitting in EX/MEM cannot forward and raises hazard.
module operand_forward
  import alu_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] rf_data,
  input  logic          exm_wr,
  input  logic          exm_load,
  input  logic [AW-1:0] exm_rd,
  input  logic [DW-1:0] exm_data,
  input  logic          wb_wr,
  input  logic [AW-1:0] wb_rd,
  input  logic [DW-1:0] wb_data,
  output logic [DW-1:0] value,
  output fwd_sel_t      sel,
  output logic          hazard
);

  // Pick the forwarding source by priority and mux the matching value.
  always_comb begin
    sel    = FWD_RF;
    value  = rf_data;
    hazard = 1'b0;
    if (addr == '0) begin
      sel   = FWD_ZERO;
      value = '0;
    end else begin
      hazard = exm_wr && exm_load && (exm_rd == addr);
      if (exm_wr && !exm_load && (exm_rd == addr)) begin
        sel   = FWD_EXM;
        value = exm_data;
      end else if (wb_wr && (wb_rd == addr)) begin
        sel   = FWD_WB;
        value = wb_data;
      end
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX register stage in front of the ALU. Accepts decoded instructions,
// resolves operands with forwarding, stalls on load-use and keeps held
// operands fresh by snooping writeback while the ALU side is stalled.
module alu_operand_stage
  import alu_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_ctrl,
  input  logic [AW-1:0]     in_rs,
  input  logic [AW-1:0]     in_rt,
  input  logic [DW-1:0]     in_rs_data,
  input  logic [DW-1:0]     in_rt_data,
  input  logic              in_uses_rt,
  input  logic              in_use_imm,
  input  logic              in_sign_ext,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [AW-1:0]     in_rd,
  input  logic              in_reg_write,
  input  logic              exm_wr,
  input  logic              exm_load,
  input  logic [AW-1:0]     exm_rd,
  input  logic [DW-1:0]     exm_data,
  input  logic              wb_wr,
  input  logic [AW-1:0]     wb_rd,
  input  logic [DW-1:0]     wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     busA,
  output logic [DW-1:0]     busB,
  output logic [2:0]        Ctrl,
  output logic [AW-1:0]     out_rd,
  output logic              out_reg_write
);

  stage_state_t  state, state_nxt;
  logic [DW-1:0] val_a, val_b, imm_ext;
  fwd_sel_t      sel_a, sel_b;
  logic          haz_a, haz_b, hazard, accept, rt_src;
  logic          snoop_a, snoop_b, drain;
  logic [AW-1:0] held_rs, held_rt;
  logic          held_a_live, held_b_live;

  operand_forward #(.DW(DW), .AW(AW)) u_fwd_a (
    .addr(in_rs), .rf_data(in_rs_data),
    .exm_wr(exm_wr), .exm_load(exm_load), .exm_rd(exm_rd), .exm_data(exm_data),
    .wb_wr(wb_wr), .wb_rd(wb_rd), .wb_data(wb_data),
    .value(val_a), .sel(sel_a), .hazard(haz_a)
  );

  operand_forward #(.DW(DW), .AW(AW)) u_fwd_b (
    .addr(in_rt), .rf_data(in_rt_data),
    .exm_wr(exm_wr), .exm_load(exm_load), .exm_rd(exm_rd), .exm_data(exm_data),
    .wb_wr(wb_wr), .wb_rd(wb_rd), .wb_data(wb_data),
    .value(val_b), .sel(sel_b), .hazard(haz_b)
  );

  // rt only matters when it really feeds busB; an immediate replaces it.
  assign rt_src  = in_uses_rt && !in_use_imm;
  assign hazard  = in_valid && (haz_a || (rt_src && haz_b));
  assign imm_ext = {{(DW-IMM_W){in_sign_ext & in_imm[IMM_W-1]}}, in_imm};
  assign out_valid = (state == ST_FULL);

  // Handshake and occupancy: flush beats everything, then accept, then drain.
  always_comb begin
    in_ready  = ((state == ST_EMPTY) || out_ready) && !hazard && !flush;
    accept    = in_valid && in_ready;
    drain     = (state == ST_FULL) && out_ready && !accept;
    state_nxt = state;
    if (flush)       state_nxt = ST_EMPTY;
    else if (accept) state_nxt = ST_FULL;
    else if (drain)  state_nxt = ST_EMPTY;
  end

  // Writeback snoop on held register sources (never on immediates or r0).
  always_comb begin
    snoop_a = wb_wr && (wb_rd != '0) && held_a_live && (wb_rd == held_rs);
    snoop_b = wb_wr && (wb_rd != '0) && held_b_live && (wb_rd == held_rt);
  end

  // Occupancy state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_EMPTY;
    else        state <= state_nxt;
  end

  // Output register: bubble when emptied, load on accept, refresh while held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busA          <= '0;
      busB          <= '0;
      Ctrl          <= ALU_NOP;
      out_rd        <= '0;
      out_reg_write <= 1'b0;
      held_rs       <= '0;
      held_rt       <= '0;
      held_a_live   <= 1'b0;
      held_b_live   <= 1'b0;
    end else if (flush || drain) begin
      busA          <= '0;
      busB          <= '0;
      Ctrl          <= ALU_NOP;
      out_rd        <= '0;
      out_reg_write <= 1'b0;
      held_rs       <= '0;
      held_rt       <= '0;
      held_a_live   <= 1'b0;
      held_b_live   <= 1'b0;
    end else if (accept) begin
      busA          <= val_a;
      busB          <= in_use_imm ? imm_ext : val_b;
      Ctrl          <= in_ctrl;
      out_rd        <= in_rd;
      out_reg_write <= in_reg_write;
      held_rs       <= in_rs;
      held_rt       <= in_rt;
      held_a_live   <= (sel_a != FWD_ZERO);
      held_b_live   <= rt_src && (sel_b != FWD_ZERO);
    end else if (state == ST_FULL) begin
      if (snoop_a) busA <= wb_data;
      if (snoop_b) busB <= wb_data;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed scenarios followed
// by randomized traffic, all checked against a behavioural stage model.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [2:0]  in_ctrl;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [31:0] in_rs_data, in_rt_data;
  logic        in_uses_rt, in_use_imm, in_sign_ext, in_reg_write;
  logic [15:0] in_imm;
  logic        exm_wr, exm_load, wb_wr, flush, out_valid, out_ready;
  logic [4:0]  exm_rd, wb_rd, out_rd;
  logic [31:0] exm_data, wb_data, busA, busB;
  logic [2:0]  Ctrl;
  logic        out_reg_write;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model of the single-entry stage.
  logic        m_full;
  logic [31:0] m_busa, m_busb;
  logic [2:0]  m_ctrl;
  logic [4:0]  m_rd, m_rs, m_rt;
  logic        m_rw, m_rt_src;

  alu_operand_stage #(.DW(32), .AW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
    .in_rs(in_rs), .in_rt(in_rt), .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
    .in_uses_rt(in_uses_rt), .in_use_imm(in_use_imm), .in_sign_ext(in_sign_ext),
    .in_imm(in_imm), .in_rd(in_rd), .in_reg_write(in_reg_write),
    .exm_wr(exm_wr), .exm_load(exm_load), .exm_rd(exm_rd), .exm_data(exm_data),
    .wb_wr(wb_wr), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .busA(busA), .busB(busB), .Ctrl(Ctrl), .out_rd(out_rd), .out_reg_write(out_reg_write)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] resolve(input logic [4:0] a, input logic [31:0] rfd);
    if (a == 5'd0) return 32'd0;
    if (exm_wr && !exm_load && exm_rd == a) return exm_data;
    if (wb_wr && wb_rd == a) return wb_data;
    return rfd;
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] imm, input logic sgn);
    int v;
    v = sgn ? int'(signed'(imm)) : int'(imm);
    return 32'(v);
  endfunction

  task automatic model_clear();
    m_full = 0; m_busa = 0; m_busb = 0; m_ctrl = 0; m_rd = 0; m_rw = 0;
    m_rs = 0; m_rt = 0; m_rt_src = 0;
  endtask

  task automatic idle();
    in_valid = 0; in_ctrl = 0; in_rs = 0; in_rt = 0; in_rd = 0;
    in_rs_data = 0; in_rt_data = 0; in_uses_rt = 0; in_use_imm = 0;
    in_sign_ext = 0; in_imm = 0; in_reg_write = 0;
    exm_wr = 0; exm_load = 0; exm_rd = 0; exm_data = 0;
    wb_wr = 0; wb_rd = 0; wb_data = 0; flush = 0; out_ready = 1;
  endtask

  task automatic checkOutput(input string tag);
    cmp({tag, ".out_valid"}, 32'(out_valid), 32'(m_full));
    cmp({tag, ".busA"}, busA, m_busa);
    cmp({tag, ".busB"}, busB, m_busb);
    cmp({tag, ".Ctrl"}, 32'(Ctrl), 32'(m_ctrl));
    cmp({tag, ".out_rd"}, 32'(out_rd), 32'(m_rd));
    cmp({tag, ".out_reg_write"}, 32'(out_reg_write), 32'(m_rw));
  endtask

  // One clock step: check in_ready, advance model at the edge, check outputs.
  task automatic applyStimulus(input string tag);
    logic e_haz, e_rdy, rt_src;
    #1;
    rt_src = in_uses_rt && !in_use_imm;
    e_haz  = in_valid && exm_load && exm_wr && exm_rd != 0 &&
             (exm_rd == in_rs || (rt_src && exm_rd == in_rt));
    e_rdy  = (!m_full || out_ready) && !e_haz && !flush;
    cmp({tag, ".in_ready"}, 32'(in_ready), 32'(e_rdy));
    @(posedge clk);
    if (flush) begin
      model_clear();
    end else if (in_valid && e_rdy) begin
      m_full = 1;
      m_busa = resolve(in_rs, in_rs_data);
      m_busb = in_use_imm ? ext16(in_imm, in_sign_ext) : resolve(in_rt, in_rt_data);
      m_ctrl = in_ctrl; m_rd = in_rd; m_rw = in_reg_write;
      m_rs = in_rs; m_rt = in_rt; m_rt_src = rt_src;
    end else if (m_full && out_ready) begin
      model_clear();
    end else if (m_full) begin
      if (wb_wr && wb_rd != 0 && wb_rd == m_rs) m_busa = wb_data;
      if (wb_wr && wb_rd != 0 && m_rt_src && wb_rd == m_rt) m_busb = wb_data;
    end
    #1;
    checkOutput(tag);
  endtask

  initial begin
    idle();
    model_clear();
    rst_n = 0;
    #12;
    checkOutput("reset");
    cmp("reset.ctrl_nop", 32'(Ctrl), 32'd0);
    rst_n = 1;

    // Idle cycles keep NOP
    applyStimulus("idle0");
    applyStimulus("idle1");

    // ADD r3 = r1 + r2, then back-to-back
    in_valid = 1; in_ctrl = 3'b001; in_rs = 1; in_rt = 2; in_rs_data = 5; in_rt_data = 7;
    in_uses_rt = 1; in_rd = 3; in_reg_write = 1;
    applyStimulus("add");
    cmp("add.busA", busA, 32'd5);
    cmp("add.busB", busB, 32'd7);
    cmp("add.Ctrl", 32'(Ctrl), 32'd1);
    cmp("add.rd", 32'(out_rd), 32'd3);
    in_ctrl = 3'b010; in_rs_data = 9; in_rt_data = 4; in_rd = 5;
    applyStimulus("b2b");
    cmp("b2b.busA", busA, 32'd9);
    cmp("b2b.Ctrl", 32'(Ctrl), 32'd2);

    // Forwarding priority and r0
    in_rs = 1; in_rs_data = 32'h11; exm_wr = 1; exm_rd = 1; exm_data = 32'hAA;
    wb_wr = 1; wb_rd = 1; wb_data = 32'hBB;
    applyStimulus("fwdprio");
    cmp("fwdprio.busA", busA, 32'hAA);
    in_rs = 0; exm_rd = 0; exm_data = 32'hCC; wb_rd = 0;
    applyStimulus("r0");
    cmp("r0.busA", busA, 32'd0);

    // Immediates
    idle();
    in_valid = 1; in_ctrl = 3'b001; in_rs = 2; in_rs_data = 1;
    in_use_imm = 1; in_uses_rt = 1; in_imm = 16'h8000; in_sign_ext = 1;
    applyStimulus("imm_sext");
    cmp("imm_sext.busB", busB, 32'hFFFF8000);
    in_sign_ext = 0;
    applyStimulus("imm_zext");
    cmp("imm_zext.busB", busB, 32'h00008000);

    // Load-use: one bubble, then MEM/WB forwarding
    idle();
    in_valid = 1; in_ctrl = 3'b001; in_rs = 4; in_rs_data = 32'hDEAD; in_rd = 7;
    exm_wr = 1; exm_load = 1; exm_rd = 4;
    applyStimulus("lu_stall");
    cmp("lu_stall.out_valid", 32'(out_valid), 32'd0);
    cmp("lu_stall.Ctrl", 32'(Ctrl), 32'd0);
    exm_wr = 0; exm_load = 0; wb_wr = 1; wb_rd = 4; wb_data = 32'h1234;
    applyStimulus("lu_fwd");
    cmp("lu_fwd.busA", busA, 32'h1234);

    // Stall snoop then flush
    idle();
    in_valid = 1; in_ctrl = 3'b001; in_rs = 6; in_rs_data = 32'h99; in_rd = 2;
    applyStimulus("hold_load");
    in_valid = 0; out_ready = 0; wb_wr = 1; wb_rd = 6; wb_data = 32'h55;
    applyStimulus("snoop");
    cmp("snoop.busA", busA, 32'h55);
    cmp("snoop.Ctrl", 32'(Ctrl), 32'd1);
    wb_wr = 0; in_valid = 1; flush = 1; in_rs = 3;
    applyStimulus("flush");
    cmp("flush.out_valid", 32'(out_valid), 32'd0);

    // Reset mid-FULL discards the entry immediately
    idle();
    in_valid = 1; in_ctrl = 3'b101; in_rs = 2; in_rs_data = 32'h77; in_rd = 9;
    in_reg_write = 1; out_ready = 0;
    applyStimulus("prereset");
    rst_n = 0;
    #1;
    model_clear();
    checkOutput("async_reset");
    #1;
    rst_n = 1;
    idle();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      in_valid     = ($urandom_range(0, 3) != 0);
      in_ctrl      = 3'($urandom_range(0, 7));
      in_rs        = 5'($urandom_range(0, 7));
      in_rt        = 5'($urandom_range(0, 7));
      in_rd        = 5'($urandom_range(0, 31));
      in_rs_data   = $urandom;
      in_rt_data   = $urandom;
      in_uses_rt   = ($urandom_range(0, 3) != 0);
      in_use_imm   = ($urandom_range(0, 2) == 0);
      in_sign_ext  = ($urandom_range(0, 1) == 1);
      in_imm       = 16'($urandom);
      in_reg_write = ($urandom_range(0, 1) == 1);
      exm_wr       = ($urandom_range(0, 1) == 1);
      exm_load     = ($urandom_range(0, 3) == 0);
      exm_rd       = 5'($urandom_range(0, 7));
      exm_data     = $urandom;
      wb_wr        = ($urandom_range(0, 1) == 1);
      wb_rd        = 5'($urandom_range(0, 7));
      wb_data      = $urandom;
      flush        = ($urandom_range(0, 15) == 0);
      out_ready    = ($urandom_range(0, 3) != 0);
      applyStimulus("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
